// File: rtl/bstep_pkg.sv
// Shared types, defaults and helper functions for the binary-step activation stream.
// Functions work on maximum-width operands; callers sign- or zero-extend into them.
package bstep_pkg;

  localparam int DEF_W           = 8;
  localparam int DEF_N_CH        = 4;
  localparam int DEF_APPROX_BITS = 2;
  localparam int DEF_CNT_W       = 16;

  localparam int MAX_W  = 64;
  localparam int MAX_CH = 64;
  localparam int POP_W  = $clog2(MAX_CH + 1);

  // Arithmetic right shift floors both operands identically, so the approximate
  // compare equals comparing the upper W-APPROX_BITS bits as signed values.
  function automatic logic step_cmp(input logic signed [MAX_W-1:0] x,
                                    input logic signed [MAX_W-1:0] thr,
                                    input logic                    approx,
                                    input int unsigned             approx_bits);
    int unsigned sh;
    sh = approx ? approx_bits : 32'd0;
    return (x >>> sh) >= (thr >>> sh);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/bstep_stream_approx_if.sv
// Stream, threshold and statistics signals of the binary-step unit.
// The master side drives beats in; the slave side is the activation unit.
interface bstep_stream_approx_if #(
  parameter int W     = 8,
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [N_CH*W-1:0]   in_data;
  logic                approx_en;
  logic                thr_wr_en;
  logic [W-1:0]        thr_wr_data;
  logic                out_valid;
  logic                out_ready;
  logic [N_CH-1:0]     out_data;
  logic                cnt_clr;
  logic [CNT_W-1:0]    fire_cnt;

  modport master (
    output in_valid, in_data, approx_en, thr_wr_en, thr_wr_data, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, fire_cnt
  );

  modport slave (
    input  in_valid, in_data, approx_en, thr_wr_en, thr_wr_data, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, fire_cnt
  );
endinterface

// File: rtl/bstep_lane_cmp.sv
// Single-lane binary step: fire = (x >= thr), optionally on floored operands.
// Purely combinational; instantiated once per lane by the top.
module bstep_lane_cmp
  import bstep_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] thr,
  input  logic                approx,
  output logic                fire
);
  logic signed [MAX_W-1:0] x_ext;
  logic signed [MAX_W-1:0] thr_ext;

  assign x_ext   = MAX_W'(x);
  assign thr_ext = MAX_W'(thr);
  assign fire    = step_cmp(x_ext, thr_ext, approx, unsigned'(APPROX_BITS));
endmodule

// File: rtl/bstep_stream_approx.sv
// Two-stage elastic binary-step activation over N_CH signed lanes with a
// saturating count of emitted ones.
module bstep_stream_approx
  import bstep_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int N_CH        = DEF_N_CH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   rst_n,
  bstep_stream_approx_if.slave  bus
);
  localparam int SUM_W = CNT_W + POP_W + 1;

  logic signed [W-1:0] thr_q;
  logic signed [W-1:0] s1_thr;
  logic [N_CH*W-1:0]   s1_data;
  logic                s1_approx;
  logic                s1_v;
  logic                s2_v;
  logic [N_CH-1:0]     s2_data;
  logic [N_CH-1:0]     cmp;
  logic [CNT_W-1:0]    cnt_q;

  logic                s1_adv;
  logic                s2_adv;
  logic                accept;
  logic                xfer;
  logic [POP_W-1:0]    pop;
  logic [SUM_W-1:0]    sum;

  assign s2_adv = !s2_v || bus.out_ready;
  assign s1_adv = !s1_v || s2_adv;
  assign accept = bus.in_valid && s1_adv;
  assign xfer   = s2_v && bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_data;
  assign bus.fire_cnt  = cnt_q;

  // Beats capture the threshold as it was before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= '0;
    end else if (bus.thr_wr_en) begin
      thr_q <= bus.thr_wr_data;
    end
  end

  // NOTE: clocked state uses <= so every register samples pre-edge values;
  // the stage-1 payload is reset too so no X reaches the compare after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_data   <= '0;
      s1_thr    <= '0;
      s1_approx <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (accept) begin
        s1_data   <= bus.in_data;
        s1_thr    <= thr_q;
        s1_approx <= bus.approx_en;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    bstep_lane_cmp #(
      .W           (W),
      .APPROX_BITS (APPROX_BITS)
    ) u_cmp (
      .x      (s1_data[i*W +: W]),
      .thr    (s1_thr),
      .approx (s1_approx),
      .fire   (cmp[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) s2_data <= cmp;
    end
  end

  assign pop = popcount(MAX_CH'(s2_data));
  assign sum = SUM_W'(cnt_q) + SUM_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

endmodule

// File: doc/bstep_stream_approx.md
Name: bstep_stream_approx

Overview:
- Pipelined, multi-channel binary-step activation unit; successor to the fixed 4-bit single-output step circuits in the activation-functions library.
- Each of N_CH signed W-bit lanes outputs 1 when x >= threshold, else 0.
- Optional approximate mode drops APPROX_BITS LSBs from the comparison for area/energy studies.
- Sits between a MAC/accumulator stream and the next layer, using valid/ready handshakes and a saturating firing-count statistic.

Parameters:
- W, 8, lane data width (signed two's complement), >= 2
- N_CH, 4, number of parallel lanes, >= 1
- APPROX_BITS, 2, LSBs ignored in approximate mode, 0..W-1
- CNT_W, 16, width of saturating firing counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_data  in  N_CH*W  lane i at bits [i*W +: W], signed
- approx_en  in  1  sampled with each accepted beat; 1 = approximate compare
- thr_wr_en  in  1  load threshold register
- thr_wr_data  in  W  signed threshold value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  N_CH  step result, bit i for lane i
- cnt_clr  in  1  synchronous clear of firing counter
- fire_cnt  out  CNT_W  saturating count of 1s emitted

Behaviour:
- Reset (async, rst_n=0): thr=0, s1/s2 valid=0, out_data=0, out_valid=0, fire_cnt=0; in_ready=1 one cycle after release.
- Threshold:
  - thr_wr_en loads thr on the clock edge.
  - A beat accepted in the same cycle uses the old thr; beats from the next cycle onward use the new thr.
  - Write-while-busy is legal; beats already in flight keep the thr captured at stage 1.
- Stage 1, on accept (in_valid & in_ready): registers lane data, approx_en and current thr.
- Stage 2: registers out_data and out_valid.
- Compare, per lane:
  - Exact: $signed(x) >= $signed(thr).
  - Approx: $signed(x[W-1:APPROX_BITS]) >= $signed(thr[W-1:APPROX_BITS]), i.e. an arithmetic floor of both operands.
  - APPROX_BITS=0 makes both modes identical.
- Latency: 2 cycles from accept to out_valid when not stalled. Throughput is 1 beat/cycle.
- Handshake, standard elastic 2-stage pipeline:
  - s2_adv = !s2_v | out_ready
  - s1_adv = !s1_v | s2_adv
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid to in_ready)
- out_data/out_valid hold stable while out_valid & !out_ready. No beat is dropped or duplicated.
- Full pipeline with out_ready=0 yields in_ready=0.
- Firing counter:
  - On output transfer (out_valid & out_ready), fire_cnt += popcount(out_data), saturating at 2^CNT_W-1; never wraps.
  - cnt_clr has priority: clear plus a same-cycle transfer gives 0.
- Reset mid-stream discards in-flight beats; outputs return to reset values immediately (async).

Decomposition:
- Shared package bstep_pkg: signed-compare function step_cmp(x, thr, approx, approx_bits); popcount function; default parameter constants.
- One sub-module, bstep_lane_cmp: purely combinational single-lane compare, instantiated N_CH times in a generate loop.
- Pipeline registers, handshake and counter stay in the top module.

Test Plan (W=8, N_CH=4, APPROX_BITS=2, CNT_W=4 unless stated):
1. thr=0, exact, lanes {-1, 0, 1, -128} (lane0 first), out_ready=1 -> out_data=4'b0110 exactly 2 cycles after accept; fire_cnt=2.
2. thr=5, lanes {4,4,4,4}: exact gives 4'b0000; approx gives 4'b1111 (4>>2=1 equals 5>>2=1). Also thr=-3, lane=-4, approx -> 1 (both floor to -1).
3. Back-to-back 6 beats; out_ready=0 for 3 cycles mid-burst -> in_ready drops once both stages are full; out_data held stable; all 6 results emerge in order with no loss or duplicate.
4. thr_wr_en with thr_wr_data=10 in the same cycle as a beat {10,10,10,10} accepted under old thr=20 -> that beat gives 0000; next beat {10,...} gives 1111.
5. Stream 5 beats of 4'b1111 -> fire_cnt saturates at 15, not 4. cnt_clr coincident with a transfer -> fire_cnt=0.
6. Assert rst_n=0 asynchronously with 2 beats in flight -> out_valid=0, fire_cnt=0 the same cycle; after release, no stale beat emerges.
